// File: rtl/piece_queue_gen_pkg.sv
// Shared game-logic types and constants for the next-piece queue and its
// bag randomizer.
package piece_queue_gen_pkg;

  typedef enum logic [2:0] {
    BLANK = 3'd0,
    I     = 3'd1,
    O     = 3'd2,
    T     = 3'd3,
    J     = 3'd4,
    L     = 3'd5,
    S     = 3'd6,
    Z     = 3'd7
  } tile_type_t;

  localparam int unsigned NEXT_PIECES_COUNT = 6;
  localparam logic [6:0]  BAG_FULL          = 7'h7F;
  localparam logic [15:0] LFSR_MASK         = 16'hB400;

endpackage

// File: rtl/piece_queue_gen_bag_select.sv
// Combinational 7-bag draw: picks one remaining piece using the low LFSR byte
// and returns the bag with that piece removed (reloaded once empty).
module bag_select
  import piece_queue_gen_pkg::*;
(
  input  logic [6:0] bag,
  input  logic [7:0] lfsr_lo,
  output tile_type_t piece,
  output logic [6:0] bag_next
);

  logic [3:0]  n;
  logic [10:0] prod;
  logic [2:0]  k;
  logic [2:0]  cnt;
  logic [2:0]  sel_idx;
  logic [6:0]  bag_cleared;

  always_comb begin
    n = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      n = n + 4'(bag[i]);
    end

    // Scale the byte into 0..n-1 without a divider.
    prod = 11'(lfsr_lo) * 11'(n);
    k    = prod[10:8];

    cnt     = '0;
    sel_idx = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      if (bag[i]) begin
        if (cnt == k) begin
          sel_idx = 3'(i);
        end
        cnt = cnt + 3'd1;
      end
    end

    piece       = tile_type_t'(3'(sel_idx + 3'd1));
    bag_cleared = bag & ~(7'd1 << sel_idx);
    bag_next    = (bag_cleared == '0) ? BAG_FULL : bag_cleared;
  end

endmodule

// File: rtl/piece_queue_gen.sv
// Upcoming-tetromino queue fed by a 7-bag randomizer over a free-running
// Galois LFSR; fills after reset/restart, then shifts one piece per pop.
module piece_queue_gen
  import piece_queue_gen_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = NEXT_PIECES_COUNT,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       restart,
  input  logic [15:0] seed,
  input  logic       pop,
  output tile_type_t pieces_queue [QUEUE_DEPTH],
  output tile_type_t next_piece,
  output logic       queue_valid
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);

  typedef enum logic {FILL, READY} state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic [6:0]  bag;
  logic [6:0]  bag_next;
  logic [CW-1:0] fill_count;
  tile_type_t  draw_piece;

  bag_select u_bag_select (
    .bag      (bag),
    .lfsr_lo  (lfsr[7:0]),
    .piece    (draw_piece),
    .bag_next (bag_next)
  );

  assign lfsr_next  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : '0);
  assign next_piece = pieces_queue[0];

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state       <= FILL;
      lfsr        <= LFSR_SEED;
      bag         <= BAG_FULL;
      fill_count  <= '0;
      queue_valid <= 1'b0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        pieces_queue[i] <= BLANK;
      end
    end else if (restart) begin
      state       <= FILL;
      lfsr        <= (seed == '0) ? LFSR_SEED : seed;
      bag         <= BAG_FULL;
      fill_count  <= '0;
      queue_valid <= 1'b0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        pieces_queue[i] <= BLANK;
      end
    end else begin
      lfsr <= lfsr_next;
      case (state)
        FILL: begin
          for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
            if (fill_count == CW'(i)) begin
              pieces_queue[i] <= draw_piece;
            end
          end
          bag        <= bag_next;
          fill_count <= fill_count + 1'b1;
          if (fill_count == CW'(QUEUE_DEPTH - 1)) begin
            state       <= READY;
            queue_valid <= 1'b1;
          end
        end
        READY: begin
          if (pop) begin
            for (int unsigned i = 0; i + 1 < QUEUE_DEPTH; i++) begin
              pieces_queue[i] <= pieces_queue[i+1];
            end
            pieces_queue[QUEUE_DEPTH-1] <= draw_piece;
            bag <= bag_next;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_queue_gen.sv
// Self-checking bench for piece_queue_gen against a list-based 7-bag model.
module tb_piece_queue_gen;
  import piece_queue_gen_pkg::*;

  localparam int QD = 6;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        restart;
  logic [15:0] seed;
  logic        pop;
  tile_type_t  pieces_queue [QD];
  tile_type_t  next_piece;
  logic        queue_valid;

  piece_queue_gen #(.QUEUE_DEPTH(QD), .LFSR_SEED(16'hACE1)) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .restart      (restart),
    .seed         (seed),
    .pop          (pop),
    .pieces_queue (pieces_queue),
    .next_piece   (next_piece),
    .queue_valid  (queue_valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: remaining bag kept as an ordered list of piece names.
  tile_type_t  m_q [QD];
  tile_type_t  m_bag [$];
  logic [15:0] m_lfsr;
  int          m_filled;
  bit          m_ready;

  tile_type_t  snap [QD];
  tile_type_t  snap_a [QD];
  tile_type_t  draws [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_refill();
    m_bag = {I, O, T, J, L, S, Z};
  endfunction

  function automatic void m_reset(input logic [15:0] s);
    m_lfsr = s;
    m_refill();
    for (int i = 0; i < QD; i++) m_q[i] = BLANK;
    m_filled = 0;
    m_ready  = 0;
  endfunction

  function automatic tile_type_t m_draw();
    int n, k;
    tile_type_t p;
    n = m_bag.size();
    k = ((int'(m_lfsr) % 256) * n) / 256;
    p = m_bag[k];
    m_bag.delete(k);
    if (m_bag.size() == 0) m_refill();
    return p;
  endfunction

  function automatic void m_edge();
    if (!rst_l) begin
      m_reset(16'hACE1);
    end else if (restart) begin
      m_reset(seed == 16'h0 ? 16'hACE1 : seed);
    end else begin
      if (!m_ready) begin
        m_q[m_filled] = m_draw();
        m_filled++;
        if (m_filled == QD) m_ready = 1;
      end else if (pop) begin
        for (int i = 0; i < QD - 1; i++) m_q[i] = m_q[i+1];
        m_q[QD-1] = m_draw();
      end
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0);
    end
  endfunction

  task automatic compare_all();
    for (int i = 0; i < QD; i++)
      check($sformatf("queue[%0d]", i), 32'(pieces_queue[i]), 32'(m_q[i]));
    check("next_piece", 32'(next_piece), 32'(m_q[0]));
    check("queue_valid", 32'(queue_valid), 32'(m_ready));
  endtask

  task automatic tick(input bit rs, input logic [15:0] sd, input bit pp);
    restart = rs;
    seed    = sd;
    pop     = pp;
    @(posedge clk);
    m_edge();
    #1;
    compare_all();
  endtask

  task automatic fill(input bit pp, output int cyc);
    cyc = 0;
    while (queue_valid !== 1'b1 && cyc < 20) begin
      tick(1'b0, 16'h0, pp);
      cyc++;
    end
    check("fill_latency", 32'(cyc), 32'(QD));
  endtask

  task automatic restart_fill(input logic [15:0] sd, input bit pp);
    int cyc;
    tick(1'b1, sd, pp);
    check("restart_valid_low", 32'(queue_valid), 32'd0);
    fill(pp, cyc);
    for (int i = 0; i < QD; i++) snap[i] = pieces_queue[i];
  endtask

  function automatic int bad_pieces(input int base, input int len);
    int bad = 0;
    for (int i = 0; i < len; i++) begin
      if (draws[base+i] == BLANK) bad++;
      for (int j = i + 1; j < len; j++)
        if (draws[base+i] == draws[base+j]) bad++;
    end
    return bad;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    tile_type_t old_q [QD];

    rst_l = 1'b0; restart = 1'b0; pop = 1'b0; seed = '0;
    m_reset(16'hACE1);
    #3;
    compare_all();
    tick(0, 16'h0, 1);
    tick(0, 16'h0, 0);

    // Reset release: exact fill latency and distinct non-blank contents
    rst_l = 1'b1;
    fill(0, cyc);
    draws = {};
    for (int i = 0; i < QD; i++) draws.push_back(pieces_queue[i]);
    check("reset_fill_distinct", 32'(bad_pieces(0, QD)), 32'd0);

    // Bag property over 70 pops from seed 1
    restart_fill(16'h0001, 0);
    draws = {};
    for (int i = 0; i < QD; i++) draws.push_back(snap[i]);
    for (int p = 0; p < 70; p++) begin
      tick(0, 16'h0, 1);
      draws.push_back(pieces_queue[QD-1]);
    end
    for (int g = 0; g + 7 <= draws.size(); g += 7)
      check($sformatf("bag_group_%0d", g / 7), 32'(bad_pieces(g, 7)), 32'd0);

    // Single pop shifts by one; idle cycle holds the queue
    for (int i = 0; i < QD; i++) old_q[i] = pieces_queue[i];
    tick(0, 16'h0, 1);
    for (int i = 0; i < QD - 1; i++)
      check($sformatf("pop_shift[%0d]", i), 32'(pieces_queue[i]), 32'(old_q[i+1]));
    for (int i = 0; i < QD; i++) old_q[i] = pieces_queue[i];
    tick(0, 16'h0, 0);
    tick(0, 16'h0, 0);
    for (int i = 0; i < QD; i++)
      check($sformatf("idle_hold[%0d]", i), 32'(pieces_queue[i]), 32'(old_q[i]));

    // pop during FILL has no effect
    restart_fill(16'h5A3C, 1);
    for (int i = 0; i < QD; i++) snap_a[i] = snap[i];
    restart_fill(16'h5A3C, 0);
    for (int i = 0; i < QD; i++)
      check($sformatf("fill_pop_ignored[%0d]", i), 32'(snap_a[i]), 32'(snap[i]));

    // restart beats pop, zero seed behaves as 16'hACE1
    tick(0, 16'h0, 1);
    restart_fill(16'h0000, 1);
    for (int i = 0; i < QD; i++) snap_a[i] = snap[i];
    restart_fill(16'hACE1, 0);
    for (int i = 0; i < QD; i++)
      check($sformatf("zero_seed[%0d]", i), 32'(snap_a[i]), 32'(snap[i]));

    // Random traffic
    for (int r = 0; r < 300; r++) begin
      logic [15:0] sd;
      sd = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      tick(bit'($urandom_range(0, 29) == 0), sd, bit'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-pop
    for (int p = 0; p < 5; p++) tick(0, 16'h0, 1);
    #2 rst_l = 1'b0;
    #1;
    m_reset(16'hACE1);
    compare_all();
    tick(0, 16'h0, 1);
    tick(0, 16'h0, 1);
    rst_l = 1'b1;
    fill(1, cyc);
    for (int p = 0; p < 20; p++) tick(0, 16'h0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
